// File: rtl/ls_pkg.sv
// Shared types and saturating helpers for the multi-zone life-support controller.
package ls_pkg;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    DEFENSE   = 2'd1,
    STEALTH   = 2'd2,
    EMERGENCY = 2'd3
  } mode_e;

  // Power drained per tick in each mode, indexed by mode_e.
  localparam logic [1:0] MODE_COST [4] = '{2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] ceil);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, ceil}) ? ceil : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : 32'd0;
  endfunction

  function automatic logic [31:0] step_toward(input logic [31:0] a, input logic [31:0] target);
    if (a < target) return a + 32'd1;
    if (a > target) return a - 32'd1;
    return a;
  endfunction

endpackage

// File: rtl/life_support_array_if.sv
// Console/hull bus of the life-support array; the controller uses the slave side.
interface life_support_array_if #(
  parameter int W     = 16,
  parameter int ZONES = 4
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

  logic [1:0]         mode_req;
  logic               load;
  logic [ZW-1:0]      load_zone;
  logic [W-1:0]       load_o2;
  logic [W-1:0]       load_temp;
  logic [W-1:0]       temp_set;
  logic [ZONES-1:0]   o2_supply;
  logic               chrg;
  logic [W-1:0]       pwr_in;
  logic               atk;
  logic [1:0]         mode_cur;
  logic [ZONES*W-1:0] o2_out;
  logic [ZONES*W-1:0] temp_out;
  logic [W-1:0]       pwr_out;
  logic [W-1:0]       shield_out;
  logic [ZONES-1:0]   zone_fatal;
  logic               fatal;

  modport master (
    output mode_req, load, load_zone, load_o2, load_temp, temp_set, o2_supply, chrg, pwr_in, atk,
    input  mode_cur, o2_out, temp_out, pwr_out, shield_out, zone_fatal, fatal
  );

  modport slave (
    input  mode_req, load, load_zone, load_o2, load_temp, temp_set, o2_supply, chrg, pwr_in, atk,
    output mode_cur, o2_out, temp_out, pwr_out, shield_out, zone_fatal, fatal
  );
endinterface

// File: rtl/ls_zone.sv
// One zone: O2/temperature regulation, load override, hazard debounce and fatal flag.
// LS_FATAL_LATCH_EN makes the fatal flag sticky until reset.
module ls_zone
  import ls_pkg::*;
#(
  parameter int W          = 16,
  parameter int O2_MAX     = 1000,
  parameter int O2_MIN     = 100,
  parameter int TEMP_MAX   = 100,
  parameter int FATAL_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  mode_e        mode,
  input  logic         supply,
  input  logic [W-1:0] temp_set,
  input  logic [W-1:0] shield,
  input  logic         load_hit,
  input  logic [W-1:0] load_o2,
  input  logic [W-1:0] load_temp,
  output logic [W-1:0] o2,
  output logic [W-1:0] temp,
  output logic         zone_fatal
);
  localparam int          HW    = $clog2(FATAL_HOLD + 1);
  localparam logic [31:0] W_MAX = 32'((64'd1 << W) - 64'd1);

  logic [W-1:0]  o2_next, temp_next;
  logic [HW-1:0] cnt, cnt_next;
  logic          unsafe;

  assign unsafe = (temp >= W'(TEMP_MAX)) || (o2 < W'(O2_MIN)) || (shield == '0);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    o2_next   = o2;
    temp_next = temp;
    cnt_next  = cnt;
    if (tick) begin
      if (supply && mode != EMERGENCY) o2_next = W'(sat_add(32'(o2), 32'd1, 32'(O2_MAX)));
      else                             o2_next = W'(sat_sub(32'(o2), 32'd1));
      case (mode)
        STEALTH:   temp_next = W'(sat_add(32'(temp), 32'd1, W_MAX));
        EMERGENCY: temp_next = W'(sat_sub(32'(temp), 32'd1));
        default:   temp_next = W'(step_toward(32'(temp), 32'(temp_set)));
      endcase
      if (!unsafe)                       cnt_next = '0;
      else if (cnt != HW'(FATAL_HOLD))   cnt_next = cnt + 1'b1;
    end
    // A console load wins over the tick update of the same zone.
    if (load_hit) begin
      o2_next   = load_o2;
      temp_next = load_temp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o2   <= W'(O2_MAX);
      temp <= '0;
      cnt  <= '0;
    end else begin
      o2   <= o2_next;
      temp <= temp_next;
      cnt  <= cnt_next;
    end
  end

`ifdef LS_FATAL_LATCH_EN
  logic stuck;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     stuck <= 1'b0;
    else if (tick && cnt_next == HW'(FATAL_HOLD)) stuck <= 1'b1;
  end
  assign zone_fatal = stuck;
`else
  assign zone_fatal = (cnt == HW'(FATAL_HOLD));
`endif

endmodule

// File: rtl/life_support_array.sv
// Multi-zone life-support controller: prescaler, mode FSM, shared power and hull shield.
// Zone fatal flags become sticky when LS_FATAL_LATCH_EN is defined.
module life_support_array
  import ls_pkg::*;
#(
  parameter int W          = 16,
  parameter int ZONES      = 4,
  parameter int PRESCALE   = 4,
  parameter int O2_MAX     = 1000,
  parameter int O2_MIN     = 100,
  parameter int TEMP_MAX   = 100,
  parameter int PWR_MAX    = 4000,
  parameter int PWR_RESUME = 50,
  parameter int SHIELD_NOM = 100,
  parameter int DMG        = 5,
  parameter int FATAL_HOLD = 8
) (
  input logic                 clk,
  input logic                 rst,
  life_support_array_if.slave bus
);
  localparam int          ZW    = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int          PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] W_MAX = 32'((64'd1 << W) - 64'd1);

  logic [PW-1:0] pre;
  logic          tick;
  mode_e         mode_q, mode_next, req;
  logic [W-1:0]  pwr_q, pwr_next, shield_q, shield_next;

  assign tick = (pre == PW'(PRESCALE - 1));
  assign req  = mode_e'(bus.mode_req);

  // NOTE: memories are never reset, but these are control registers, so all of them are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      mode_q   <= NORMAL;
      pwr_q    <= '0;
      shield_q <= W'(SHIELD_NOM);
    end else begin
      pre      <= tick ? '0 : pre + 1'b1;
      mode_q   <= mode_next;
      pwr_q    <= pwr_next;
      shield_q <= shield_next;
    end
  end

  // Next mode, power and shield all derive from the pre-tick state.
  always_comb begin
    mode_next   = mode_q;
    pwr_next    = pwr_q;
    shield_next = shield_q;
    if (tick) begin
      if (pwr_q == '0) begin
        mode_next = EMERGENCY;
      end else if (mode_q == EMERGENCY) begin
        if (pwr_q >= W'(PWR_RESUME) && req != EMERGENCY) mode_next = req;
      end else begin
        mode_next = req;
      end

      if (bus.chrg) pwr_next = W'(sat_add(32'(pwr_q), 32'(bus.pwr_in), 32'(PWR_MAX)));
      else          pwr_next = W'(sat_sub(32'(pwr_q), 32'(MODE_COST[mode_q])));

      if (bus.atk)                shield_next = W'(sat_sub(32'(shield_q), 32'(DMG)));
      else if (mode_q == DEFENSE) shield_next = W'(sat_add(32'(shield_q), 32'd2, W_MAX));
      else                        shield_next = W'(step_toward(32'(shield_q), 32'(SHIELD_NOM)));
    end
  end

  for (genvar i = 0; i < ZONES; i++) begin : g_zone
    ls_zone #(
      .W(W), .O2_MAX(O2_MAX), .O2_MIN(O2_MIN), .TEMP_MAX(TEMP_MAX), .FATAL_HOLD(FATAL_HOLD)
    ) u_zone (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .mode      (mode_q),
      .supply    (bus.o2_supply[i]),
      .temp_set  (bus.temp_set),
      .shield    (shield_q),
      .load_hit  (bus.load && (bus.load_zone == ZW'(i))),
      .load_o2   (bus.load_o2),
      .load_temp (bus.load_temp),
      .o2        (bus.o2_out[i*W +: W]),
      .temp      (bus.temp_out[i*W +: W]),
      .zone_fatal(bus.zone_fatal[i])
    );
  end

  assign bus.mode_cur   = mode_q;
  assign bus.pwr_out    = pwr_q;
  assign bus.shield_out = shield_q;
  assign bus.fatal      = |bus.zone_fatal;

endmodule
